axi_cmd_sequencer: RTL and testbench
====================================

Name: axi_cmd_sequencer

Overview:
- Sits on the AXI side of the AXI-to-AHB bridge, between the AXI slave ports and the bridge's command/data FIFOs.
- Round-robin arbitrates AW vs AR and expands each accepted burst into per-beat commands: address, write/read flag, {last, id} and size, plus write data and strobe.
- Pushes one FIFO entry set per beat with full-flag backpressure, so the AHB side only ever sees single-beat commands.

Parameters:
AXI_ID_WIDTH, 8, AXI ID width; cmd_id is AXI_ID_WIDTH+1 bits wide.
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 64, data width; the strobe is DATA_WIDTH/8 bits wide.

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
awid/awaddr/awlen/awsize/awburst/awvalid  in  ID/ADDR/8/3/2/1  AXI write address
awready  out  1  AW handshake
wdata/wstrb/wlast/wvalid  in  DATA/DATA/8/1/1  AXI write data
wready  out  1  W handshake
arid/araddr/arlen/arsize/arburst/arvalid  in  ID/ADDR/8/3/2/1  AXI read address
arready  out  1  AR handshake
cmd_w_en  out  1  push strobe, common to the addr/state/id/size FIFOs
cmd_addr  out  ADDR  beat address
cmd_write  out  1  1 = write, 0 = read
cmd_id  out  ID+1  {last_beat, id}
cmd_size  out  3  beat size
data_w_en  out  1  data FIFO push strobe (write beats only)
cmd_data  out  DATA  wdata
cmd_strb  out  DATA/8  wstrb
cmd_fifo_full  in  1  OR of the addr/state/id/size FIFO full flags
data_fifo_full  in  1  data FIFO full
busy  out  1  state != IDLE
err_pulse  out  1  one-cycle flag on a protocol violation

Behaviour:
- Reset (areset high at a clock edge):
  - State returns to IDLE; priority pointer = write.
  - All outputs are 0: awready, arready, wready, cmd_w_en, data_w_en, busy, err_pulse.
  - Any in-flight burst is dropped with no further pushes.
  - Reset mid-burst is legal and needs no flush.
- States:
  - IDLE: arbitration.
  - WR_BEAT: issuing write beats.
  - RD_BEAT: issuing read beats.
- IDLE arbitration (combinational readies):
  - awready = awvalid & (!arvalid | prio==W).
  - arready = arvalid & (!awvalid | prio==R).
  - Only one ready is ever high at a time.
- On a handshake:
  - Latch id, addr, len, size and burst.
  - Set beat_cnt = 0.
  - Flip the priority pointer away from the granted channel.
  - Go to WR_BEAT or RD_BEAT.
  - The earliest first push is the cycle after the handshake.
- WR_BEAT:
  - wready = !cmd_fifo_full & !data_fifo_full.
  - On wvalid & wready, cmd_w_en and data_w_en pulse together with cmd_write=1 and the current addr, size, data and strobe.
- RD_BEAT:
  - cmd_w_en = !cmd_fifo_full, with cmd_write=0; data_w_en stays 0.
- Every beat:
  - cmd_id = {beat_cnt==len, id}.
  - One beat per cycle at most; a full flag stalls the beat with no push and no address advance.
- After the push of beat len, return to IDLE.
  - Arbitration is re-evaluated the next cycle, so there is a minimum of 1 bubble cycle between bursts.
- Address generation, with bytes = 1<<size:
  - FIXED (0): the address is held.
  - INCR (1): addr += bytes, modulo 2^ADDR_WIDTH.
  - WRAP (2): wrap_bytes = (len+1)*bytes; the next address wraps to the aligned boundary when it reaches boundary + wrap_bytes.
  - burst==3 (reserved) is treated as INCR and raises err_pulse at the handshake.
- Width rules:
  - size > 3 is clamped to 3 and raises err_pulse at the handshake.
  - WRAP with len not in {1,3,7,15} is treated as INCR and raises err_pulse.
- wlast mismatch:
  - If wlast is 1 on a beat before beat len, or 0 on beat len, raise err_pulse on that push.
  - Burst length always follows awlen; wlast is never used for sequencing.
- Simultaneous awvalid and arvalid at reset exit: write wins.
- The block raises no ready while busy.
- 4 KB boundary crossing is not checked; it is the master's responsibility.

Decomposition:
- Shared package (bridge_pkg): burst encodings (FIXED/INCR/WRAP), state enum, MAX_SIZE=3.
- Sub-module axi_burst_addr_gen: combinational next-address calculation from (addr, size, len, burst).
- Arbiter and FSM stay in the top block.

Test Plan:
1. INCR write: awaddr=0x1000, awlen=3, awsize=3, W beats back-to-back.
   - Expect 4 pushes at 0x1000/0x1008/0x1010/0x1018.
   - Expect cmd_id last bit = 1 only on the 4th beat; no err_pulse.
2. WRAP read: araddr=0x2038, arlen=3, arsize=3.
   - Expect addresses 0x2038, 0x2020, 0x2028, 0x2030, with cmd_write=0 and data_w_en never set.
3. awvalid and arvalid both held high continuously, each with len=0.
   - Expect grants to alternate W, R, W, R, first grant W.
   - Expect 1 idle cycle between grants.
4. Backpressure: cmd_fifo_full high for 5 cycles during beat 2 of an 8-beat INCR write.
   - Expect wready=0 and no push for those cycles, then resume at the same address.
   - Expect 8 pushes in total.
5. Errors:
   - awsize=5 -> cmd_size=3 and err_pulse at the handshake.
   - awlen=1 with wlast=1 on beat 0 -> err_pulse on beat 0; 2 pushes still occur.
6. areset asserted for 1 cycle mid-read (beat 1 of 4).
   - Expect busy=0 and no pushes after reset.
   - Expect the next arvalid to be accepted normally with prio=W.

Source files
------------

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared burst encodings, FSM states and limits for the AXI command sequencer
package bridge_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_BEAT = 2'd1,
      ST_RD_BEAT = 2'd2
   } state_t;

   localparam logic [2:0] MAX_SIZE = 3'd3;

   function automatic logic is_wrap_len(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_cmd_sequencer_if.sv
// rtl/axi_cmd_sequencer_if.sv - AXI AW/W/AR slave side plus command/data FIFO push side
interface axi_cmd_sequencer_if #(
   parameter int AXI_ID_WIDTH = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64
);
   logic [AXI_ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0]     awaddr;
   logic [7:0]                awlen;
   logic [2:0]                awsize;
   logic [1:0]                awburst;
   logic                      awvalid;
   logic                      awready;
   logic [DATA_WIDTH-1:0]     wdata;
   logic [DATA_WIDTH/8-1:0]   wstrb;
   logic                      wlast;
   logic                      wvalid;
   logic                      wready;
   logic [AXI_ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0]     araddr;
   logic [7:0]                arlen;
   logic [2:0]                arsize;
   logic [1:0]                arburst;
   logic                      arvalid;
   logic                      arready;
   logic                      cmd_w_en;
   logic [ADDR_WIDTH-1:0]     cmd_addr;
   logic                      cmd_write;
   logic [AXI_ID_WIDTH:0]     cmd_id;
   logic [2:0]                cmd_size;
   logic                      data_w_en;
   logic [DATA_WIDTH-1:0]     cmd_data;
   logic [DATA_WIDTH/8-1:0]   cmd_strb;
   logic                      cmd_fifo_full;
   logic                      data_fifo_full;
   logic                      busy;
   logic                      err_pulse;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output cmd_w_en, cmd_addr, cmd_write, cmd_id, cmd_size,
      output data_w_en, cmd_data, cmd_strb,
      input  cmd_fifo_full, data_fifo_full,
      output busy, err_pulse
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  cmd_w_en, cmd_addr, cmd_write, cmd_id, cmd_size,
      input  data_w_en, cmd_data, cmd_strb,
      output cmd_fifo_full, data_fifo_full,
      input  busy, err_pulse
   );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// rtl/axi_burst_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_burst_addr_gen
   import bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]            i_size,
   input  logic [7:0]            i_len,
   input  burst_t                i_burst,
   output logic [ADDR_WIDTH-1:0] o_next_addr
);

   logic [ADDR_WIDTH-1:0] w_bytes;
   logic [ADDR_WIDTH-1:0] w_wrap_bytes;
   logic [ADDR_WIDTH-1:0] w_boundary;
   logic [ADDR_WIDTH-1:0] w_incr;

   assign w_bytes      = ADDR_WIDTH'(1) << i_size;
   assign w_wrap_bytes = (ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size;
   assign w_boundary   = i_addr & ~(w_wrap_bytes - ADDR_WIDTH'(1));
   assign w_incr       = i_addr + w_bytes;

   always_comb begin
      o_next_addr = w_incr;
      case (i_burst)
         BURST_FIXED: o_next_addr = i_addr;
         BURST_WRAP:  o_next_addr = (w_incr == w_boundary + w_wrap_bytes) ? w_boundary : w_incr;
         default:     o_next_addr = w_incr;
      endcase
   end

endmodule

// File: rtl/axi_cmd_sequencer.sv
// rtl/axi_cmd_sequencer.sv - round-robin AW/AR arbiter expanding AXI bursts into single-beat FIFO pushes
module axi_cmd_sequencer
   import bridge_pkg::*;
#(
   parameter int AXI_ID_WIDTH = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64
) (
   input  logic              aclk,
   input  logic              areset,
   axi_cmd_sequencer_if.slave bus
);

   state_t                  r_state;
   logic                    r_prio;          // 0: write channel has priority, 1: read
   logic [AXI_ID_WIDTH-1:0] r_id;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_len;
   logic [2:0]              r_size;
   burst_t                  r_burst;
   logic [7:0]              r_beat_cnt;

   logic                    w_idle;
   logic                    w_awready;
   logic                    w_arready;
   logic                    w_hs;
   logic [2:0]              w_sel_size;
   logic [1:0]              w_sel_burst;
   logic [7:0]              w_sel_len;
   logic                    w_size_err;
   logic                    w_rsvd_err;
   logic                    w_wraplen_err;
   burst_t                  w_eff_burst;
   logic [2:0]              w_eff_size;
   logic                    w_last_beat;
   logic                    w_wready;
   logic                    w_wr_push;
   logic                    w_rd_push;
   logic                    w_push;
   logic                    w_wlast_err;
   logic [ADDR_WIDTH-1:0]   w_next_addr;
   logic [DATA_WIDTH-1:0]   w_data;

   assign w_idle    = (r_state == ST_IDLE) && !areset;
   assign w_awready = w_idle && bus.awvalid && (!bus.arvalid || !r_prio);
   assign w_arready = w_idle && bus.arvalid && (!bus.awvalid ||  r_prio);
   assign w_hs      = w_awready || w_arready;

   assign w_sel_size  = w_awready ? bus.awsize  : bus.arsize;
   assign w_sel_burst = w_awready ? bus.awburst : bus.arburst;
   assign w_sel_len   = w_awready ? bus.awlen   : bus.arlen;

   assign w_size_err    = w_sel_size > MAX_SIZE;
   assign w_rsvd_err    = w_sel_burst == BURST_RSVD;
   assign w_wraplen_err = (w_sel_burst == BURST_WRAP) && !is_wrap_len(w_sel_len);
   assign w_eff_burst   = (w_rsvd_err || w_wraplen_err) ? BURST_INCR : burst_t'(w_sel_burst);
   assign w_eff_size    = w_size_err ? MAX_SIZE : w_sel_size;

   assign w_last_beat = r_beat_cnt == r_len;
   assign w_wready    = (r_state == ST_WR_BEAT) && !areset && !bus.cmd_fifo_full && !bus.data_fifo_full;
   assign w_wr_push   = w_wready && bus.wvalid;
   assign w_rd_push   = (r_state == ST_RD_BEAT) && !areset && !bus.cmd_fifo_full;
   assign w_push      = w_wr_push || w_rd_push;
   // wlast is only cross-checked against awlen; it never ends the burst
   assign w_wlast_err = w_wr_push && (bus.wlast != w_last_beat);

   axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
      .i_addr      (r_addr),
      .i_size      (r_size),
      .i_len       (r_len),
      .i_burst     (r_burst),
      .o_next_addr (w_next_addr)
   );

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state    <= ST_IDLE;
         r_prio     <= 1'b0;
         r_id       <= '0;
         r_addr     <= '0;
         r_len      <= '0;
         r_size     <= '0;
         r_burst    <= BURST_INCR;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_hs) begin
                  r_id       <= w_awready ? bus.awid   : bus.arid;
                  r_addr     <= w_awready ? bus.awaddr : bus.araddr;
                  r_len      <= w_sel_len;
                  r_size     <= w_eff_size;
                  r_burst    <= w_eff_burst;
                  r_beat_cnt <= '0;
                  r_prio     <= w_awready;
                  r_state    <= w_awready ? ST_WR_BEAT : ST_RD_BEAT;
               end
            end
            ST_WR_BEAT, ST_RD_BEAT: begin
               if (w_push) begin
                  if (w_last_beat) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 8'd1;
                     r_addr     <= w_next_addr;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_data = bus.wdata;

   assign bus.awready   = w_awready;
   assign bus.arready   = w_arready;
   assign bus.wready    = w_wready;
   assign bus.cmd_w_en  = w_push;
   assign bus.cmd_addr  = r_addr;
   assign bus.cmd_write = r_state == ST_WR_BEAT;
   assign bus.cmd_id    = {w_last_beat, r_id};
   assign bus.cmd_size  = r_size;
   assign bus.data_w_en = w_wr_push;
   assign bus.cmd_data  = w_data;
   assign bus.cmd_strb  = bus.wstrb;
   assign bus.busy      = (r_state != ST_IDLE) && !areset;
   assign bus.err_pulse = (w_hs && (w_size_err || w_rsvd_err || w_wraplen_err)) || w_wlast_err;

endmodule

// File: tb/tb_axi_cmd_sequencer.sv
// tb/tb_axi_cmd_sequencer.sv - scoreboard bench for axi_cmd_sequencer
module tb_axi_cmd_sequencer;
   import bridge_pkg::*;

   localparam int IDW = 8;
   localparam int AW  = 32;
   localparam int DW  = 64;
   localparam int SW  = DW / 8;

   logic aclk = 1'b0;
   logic areset;
   always #5 aclk = ~aclk;

   axi_cmd_sequencer_if #(.AXI_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_cmd_sequencer #(.AXI_ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus.slave)
   );

   typedef struct {
      logic [AW-1:0]  addr;
      logic           write;
      logic [IDW:0]   id;
      logic [2:0]     size;
      logic [DW-1:0]  data;
      logic [SW-1:0]  strb;
   } push_t;

   push_t exp_q[$];
   push_t mon_e;
   int n_tests = 0;
   int n_fail  = 0;
   int n_push  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_push(input logic [AW-1:0] addr, input logic wr, input logic last,
                           input logic [IDW-1:0] id, input logic [2:0] size,
                           input logic [DW-1:0] data, input logic [SW-1:0] strb);
      push_t e;
      e.addr = addr; e.write = wr; e.id = {last, id}; e.size = size; e.data = data; e.strb = strb;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: every push is matched against the head of the expected queue
   always @(negedge aclk) begin
      if (bus.cmd_w_en === 1'b1) begin
         n_push++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_push: got addr 0x%0h, expected no push", bus.cmd_addr);
         end else begin
            mon_e = exp_q.pop_front();
            check("push_addr", 64'(bus.cmd_addr), 64'(mon_e.addr));
            check("push_write", 64'(bus.cmd_write), 64'(mon_e.write));
            check("push_id", 64'(bus.cmd_id), 64'(mon_e.id));
            check("push_size", 64'(bus.cmd_size), 64'(mon_e.size));
            check("push_data_w_en", 64'(bus.data_w_en), 64'(mon_e.write));
            if (mon_e.write) begin
               check("push_data", bus.cmd_data, mon_e.data);
               check("push_strb", 64'(bus.cmd_strb), 64'(mon_e.strb));
            end
         end
      end else if (bus.data_w_en === 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL lone_data_w_en: got 1, expected 0");
      end
   end

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic do_addr(input logic wr, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                          input logic exp_err);
      int t;
      if (wr) begin
         bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
         bus.awvalid = 1'b1;
      end else begin
         bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
         bus.arvalid = 1'b1;
      end
      t = 0;
      while (1) begin
         @(negedge aclk);
         if ((wr ? bus.awready : bus.arready) === 1'b1) break;
         t++;
         if (t > 50) begin
            check("addr_hs_timeout", 64'd0, 64'd1);
            break;
         end
      end
      check("hs_err_pulse", 64'(bus.err_pulse), 64'(exp_err));
      tick();
      bus.awvalid = 1'b0;
      bus.arvalid = 1'b0;
   endtask

   task automatic do_w(input int len, input logic [DW-1:0] dbase, input int flip_beat, input int stall_beat);
      int t;
      for (int i = 0; i <= len; i++) begin
         bus.wvalid = 1'b1;
         bus.wdata  = dbase + DW'(i);
         bus.wstrb  = 8'hFF ^ 8'(i);
         bus.wlast  = (i == len) ^ (i == flip_beat);
         if (i == stall_beat) begin
            bus.cmd_fifo_full = 1'b1;
            repeat (5) begin
               @(negedge aclk);
               check("stall_wready", 64'(bus.wready), 64'd0);
               check("stall_no_push", 64'(bus.cmd_w_en), 64'd0);
               tick();
            end
            bus.cmd_fifo_full = 1'b0;
         end
         t = 0;
         while (1) begin
            @(negedge aclk);
            if (bus.wready === 1'b1) break;
            t++;
            if (t > 50) begin
               check("w_timeout", 64'd0, 64'd1);
               break;
            end
         end
         check("beat_err_pulse", 64'(bus.err_pulse), 64'(i == flip_beat));
         tick();
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
   endtask

   task automatic drain;
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(negedge aclk);
         t++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      tick();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int gcnt;
      int gcyc[4];
      logic gwr[4];
      int cyc;
      int p0;

      areset = 1'b1;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = 2'd1; bus.awvalid = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = 2'd1; bus.arvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.cmd_fifo_full = 1'b0; bus.data_fifo_full = 1'b0;

      // Reset state with both valids already asserted
      bus.awid = 8'h11; bus.awaddr = 32'h100; bus.awsize = 3'd3;
      bus.arid = 8'h22; bus.araddr = 32'h200; bus.arsize = 3'd3;
      bus.awvalid = 1'b1; bus.arvalid = 1'b1;
      bus.wvalid = 1'b1; bus.wlast = 1'b1; bus.wdata = 64'hDEAD_BEEF_0000_0001; bus.wstrb = 8'hFF;
      tick(); tick();
      @(negedge aclk);
      check("rst_awready", 64'(bus.awready), 64'd0);
      check("rst_arready", 64'(bus.arready), 64'd0);
      check("rst_wready", 64'(bus.wready), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_err", 64'(bus.err_pulse), 64'd0);
      check("rst_data_w_en", 64'(bus.data_w_en), 64'd0);

      // Alternating grants, write first at reset exit
      exp_push(32'h100, 1'b1, 1'b1, 8'h11, 3'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      exp_push(32'h200, 1'b0, 1'b1, 8'h22, 3'd3, 64'h0, 8'h0);
      exp_push(32'h100, 1'b1, 1'b1, 8'h11, 3'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      exp_push(32'h200, 1'b0, 1'b1, 8'h22, 3'd3, 64'h0, 8'h0);
      tick();
      areset = 1'b0;
      gcnt = 0;
      cyc = 0;
      while (gcnt < 4 && cyc < 40) begin
         @(negedge aclk);
         if (bus.awready === 1'b1 || bus.arready === 1'b1) begin
            gwr[gcnt]  = bus.awready;
            gcyc[gcnt] = cyc;
            gcnt++;
         end
         cyc++;
         tick();
      end
      bus.awvalid = 1'b0; bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
      check("grant_count", 64'(gcnt), 64'd4);
      for (int k = 0; k < 4; k++) begin
         check("grant_order", 64'(gwr[k]), 64'((k % 2) == 0));
         if (k > 0) check("grant_gap", 64'(gcyc[k] - gcyc[k-1]), 64'd2);
      end
      drain();

      // INCR write, 4 beats of 8 bytes
      for (int i = 0; i < 4; i++)
         exp_push(32'h1000 + 32'(8 * i), 1'b1, i == 3, 8'h01, 3'd3, 64'h1000 + 64'(i), 8'hFF ^ 8'(i));
      do_addr(1'b1, 8'h01, 32'h1000, 8'd3, 3'd3, 2'd1, 1'b0);
      do_w(3, 64'h1000, -1, -1);
      drain();

      // WRAP read crossing the 32-byte boundary
      exp_push(32'h2038, 1'b0, 1'b0, 8'h02, 3'd3, 64'h0, 8'h0);
      exp_push(32'h2020, 1'b0, 1'b0, 8'h02, 3'd3, 64'h0, 8'h0);
      exp_push(32'h2028, 1'b0, 1'b0, 8'h02, 3'd3, 64'h0, 8'h0);
      exp_push(32'h2030, 1'b0, 1'b1, 8'h02, 3'd3, 64'h0, 8'h0);
      do_addr(1'b0, 8'h02, 32'h2038, 8'd3, 3'd3, 2'd2, 1'b0);
      drain();

      // Backpressure on beat 2 of an 8-beat INCR write
      p0 = n_push;
      for (int i = 0; i < 8; i++)
         exp_push(32'h4000 + 32'(4 * i), 1'b1, i == 7, 8'h03, 3'd2, 64'h4000 + 64'(i), 8'hFF ^ 8'(i));
      do_addr(1'b1, 8'h03, 32'h4000, 8'd7, 3'd2, 2'd1, 1'b0);
      do_w(7, 64'h4000, -1, 2);
      drain();
      check("bp_push_count", 64'(n_push - p0), 64'd8);

      // Oversize awsize is clamped and flagged
      exp_push(32'h5000, 1'b1, 1'b1, 8'h04, 3'd3, 64'h5000, 8'hFF);
      do_addr(1'b1, 8'h04, 32'h5000, 8'd0, 3'd5, 2'd1, 1'b1);
      do_w(0, 64'h5000, -1, -1);
      drain();

      // Early wlast on beat 0 of a 2-beat write
      p0 = n_push;
      exp_push(32'h5100, 1'b1, 1'b0, 8'h05, 3'd3, 64'h5100, 8'hFF);
      exp_push(32'h5108, 1'b1, 1'b1, 8'h05, 3'd3, 64'h5101, 8'hFE);
      do_addr(1'b1, 8'h05, 32'h5100, 8'd1, 3'd3, 2'd1, 1'b0);
      do_w(1, 64'h5100, 0, -1);
      drain();
      check("wlast_push_count", 64'(n_push - p0), 64'd2);

      // Reserved burst behaves as INCR and is flagged; FIXED holds the address
      exp_push(32'h6000, 1'b0, 1'b0, 8'h08, 3'd2, 64'h0, 8'h0);
      exp_push(32'h6004, 1'b0, 1'b1, 8'h08, 3'd2, 64'h0, 8'h0);
      do_addr(1'b0, 8'h08, 32'h6000, 8'd1, 3'd2, 2'd3, 1'b1);
      drain();
      for (int i = 0; i < 3; i++)
         exp_push(32'h7002, 1'b0, i == 2, 8'h09, 3'd1, 64'h0, 8'h0);
      do_addr(1'b0, 8'h09, 32'h7002, 8'd2, 3'd1, 2'd0, 1'b0);
      drain();

      // Reset during beat 1 of a 4-beat read drops the rest of the burst
      exp_push(32'h3000, 1'b0, 1'b0, 8'h06, 3'd2, 64'h0, 8'h0);
      do_addr(1'b0, 8'h06, 32'h3000, 8'd3, 3'd2, 2'd1, 1'b0);
      tick();
      areset = 1'b1;
      tick();
      areset = 1'b0;
      p0 = n_push;
      @(negedge aclk);
      check("post_rst_busy", 64'(bus.busy), 64'd0);
      repeat (5) tick();
      check("post_rst_pushes", 64'(n_push - p0), 64'd0);
      check("post_rst_queue", 64'(exp_q.size()), 64'd0);
      exp_push(32'h3100, 1'b0, 1'b1, 8'h07, 3'd2, 64'h0, 8'h0);
      do_addr(1'b0, 8'h07, 32'h3100, 8'd0, 3'd2, 2'd1, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
